// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall/flush controller for the five-stage MIPS pipeline.
// Mealy control outputs; state, wait counter, timeout flag and statistics are registered.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_MemRead,
   input  logic [4:0]  ex_register_dest,
   input  logic        mem_Branch,
   input  logic        mem_zero,
   input  logic        mem_MemRead,
   input  logic        mem_MemWrite,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_write,
   output logic        exmem_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_flush,
   output logic        memwb_bubble,
   output logic        pc_src,
   output logic        mem_err,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;
   logic       memop, taken, load_use, hold;
   logic       stall_ev, flush_ev;

   assign memop    = mem_MemRead | mem_MemWrite;
   assign taken    = mem_Branch & mem_zero;
   assign load_use = ex_MemRead && (ex_register_dest != 5'd0) &&
                     ((ex_register_dest == id_rs) || (id_uses_rt && (ex_register_dest == id_rt)));
   assign hold     = (state == MEM_WAIT) ? !dmem_ready : (memop && !dmem_ready);
   assign stall_ev = hold || (!taken && load_use);
   assign flush_ev = !hold && taken;
   assign wait_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      pc_src       = 1'b0;
      if (!rst_n) begin
         // Hold every register and keep NOPs flowing while reset is asserted
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_flush  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (hold) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (taken) begin
         pc_src       = 1'b1;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_flush  = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_bubble  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         mem_err     <= 1'b0;
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         case (state)
            RUN: begin
               if (hold) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  state <= RUN;
               end else begin
                  // Flag the timeout at the same edge the counter reaches it; keep waiting
                  wait_cnt <= wait_nxt;
                  if (wait_nxt >= TIMEOUT) mem_err <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
         if (stall_ev && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
         if (flush_ev && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int TO = 4;
   localparam logic [8:0] C_RST    = 9'b0000_1111_0;
   localparam logic [8:0] C_NORMAL = 9'b1111_0000_0;
   localparam logic [8:0] C_HOLD   = 9'b0000_0001_0;
   localparam logic [8:0] C_BRANCH = 9'b1111_1110_1;
   localparam logic [8:0] C_STALL  = 9'b0011_0100_0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_register_dest = '0;
   logic id_uses_rt = 0, ex_MemRead = 0, mem_Branch = 0, mem_zero = 0;
   logic mem_MemRead = 0, mem_MemWrite = 0, dmem_ready = 1;
   logic pc_write, ifid_write, idex_write, exmem_write;
   logic ifid_flush, idex_bubble, exmem_flush, memwb_bubble, pc_src, mem_err;
   logic [15:0] stall_count, flush_count;
   logic [8:0] ctl;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit m_wait, m_err;
   int m_wcnt, m_stall, m_flush;
   logic [8:0] m_exp;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_MemRead(ex_MemRead), .ex_register_dest(ex_register_dest),
      .mem_Branch(mem_Branch), .mem_zero(mem_zero), .mem_MemRead(mem_MemRead),
      .mem_MemWrite(mem_MemWrite), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .pc_src(pc_src),
      .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
   );

   assign ctl = {pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_bubble, exmem_flush, memwb_bubble, pc_src};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle reference: outputs derived from the priority rules, then next-cycle bookkeeping
   always @(negedge clk) begin
      bit memop, taken, lu, hold;
      memop = mem_MemRead | mem_MemWrite;
      taken = mem_Branch & mem_zero;
      lu = ex_MemRead && ex_register_dest != 0 &&
           (ex_register_dest == id_rs || (id_uses_rt && ex_register_dest == id_rt));
      if (!rst_n) begin
         m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
      end
      check("model_stall_count", stall_count, m_stall);
      check("model_flush_count", flush_count, m_flush);
      check("model_mem_err", mem_err, m_err);
      hold = m_wait ? !dmem_ready : (memop && !dmem_ready);
      if (!rst_n)     m_exp = C_RST;
      else if (hold)  m_exp = C_HOLD;
      else if (taken) m_exp = C_BRANCH;
      else if (lu)    m_exp = C_STALL;
      else            m_exp = C_NORMAL;
      check("model_ctl", ctl, m_exp);
      if (rst_n) begin
         if (hold) begin
            if (m_wait) begin
               m_wcnt = (m_wcnt < 255) ? m_wcnt + 1 : 255;
               if (m_wcnt >= TO) m_err = 1;
            end else m_wcnt = 0;
         end
         m_wait = hold;
         if (hold || (!taken && lu)) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
         if (!hold && taken) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      end
   end

   task automatic next_cycle(); @(posedge clk); #1; endtask
   task automatic sample(); @(negedge clk); #1; endtask
   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_MemRead = 0; ex_register_dest = 0;
      mem_Branch = 0; mem_zero = 0; mem_MemRead = 0; mem_MemWrite = 0; dmem_ready = 1;
   endtask

   initial begin
      #3;
      check("reset_ctl", ctl, C_RST);
      check("reset_counts", {stall_count, flush_count}, 32'd0);
      check("reset_err", mem_err, 0);
      next_cycle();
      next_cycle(); rst_n = 1;
      sample(); check("normal", ctl, C_NORMAL);

      // load-use
      next_cycle(); ex_MemRead = 1; ex_register_dest = 5; id_rs = 5;
      sample(); check("load_use", ctl, C_STALL);
      next_cycle(); ex_MemRead = 0;
      sample(); check("load_use_clear", ctl, C_NORMAL);
      check("load_use_count", stall_count, 1);
      next_cycle(); ex_MemRead = 1; ex_register_dest = 0; id_rs = 0;
      sample(); check("load_r0", ctl, C_NORMAL);
      next_cycle(); ex_register_dest = 7; id_rt = 7; id_uses_rt = 0;
      sample(); check("load_rt_unused", ctl, C_NORMAL);
      next_cycle(); id_uses_rt = 1;
      sample(); check("load_rt_used", ctl, C_STALL);
      next_cycle(); idle();
      sample(); check("stall_count2", stall_count, 2);

      // taken branch
      next_cycle(); mem_Branch = 1; mem_zero = 1;
      sample(); check("branch", ctl, C_BRANCH);
      next_cycle(); mem_zero = 0;
      sample(); check("branch_not_taken", ctl, C_NORMAL);
      check("flush_count1", flush_count, 1);

      // memory wait of 3 ready-low cycles
      next_cycle(); idle(); mem_MemRead = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) next_cycle();
         sample(); check("mem_hold", ctl, C_HOLD);
      end
      next_cycle(); dmem_ready = 1;
      sample(); check("mem_release", ctl, C_NORMAL);
      next_cycle(); idle();
      sample(); check("mem_stalls", stall_count, 5);
      check("mem_no_err", mem_err, 0);

      // branch beats load-use
      next_cycle(); mem_Branch = 1; mem_zero = 1; ex_MemRead = 1; ex_register_dest = 3; id_rs = 3;
      sample(); check("prio_branch", ctl, C_BRANCH);
      next_cycle(); idle();
      sample(); check("prio_counts", {stall_count, flush_count}, {16'd5, 16'd2});

      // hold beats branch
      next_cycle(); mem_Branch = 1; mem_zero = 1; mem_MemWrite = 1; dmem_ready = 0;
      sample(); check("prio_hold", ctl, C_HOLD);
      next_cycle(); dmem_ready = 1;
      sample(); check("branch_after_release", ctl, C_BRANCH);
      next_cycle(); idle();

      // timeout: 10 ready-low cycles, first in RUN
      next_cycle(); mem_MemRead = 1; dmem_ready = 0;
      for (int c = 1; c <= 10; c++) begin
         sample(); check("timeout_hold", ctl, C_HOLD);
         if (c == 5) check("err_before", mem_err, 0);
         if (c == 6) check("err_after", mem_err, 1);
         if (c < 10) next_cycle();
      end
      next_cycle(); dmem_ready = 1;
      sample(); check("timeout_release", ctl, C_NORMAL);
      next_cycle(); idle();
      sample(); check("err_sticky", mem_err, 1);

      // reset mid-wait
      next_cycle(); mem_MemRead = 1; dmem_ready = 0;
      repeat (4) next_cycle();
      rst_n = 0; #1;
      check("rst_async_ctl", ctl, C_RST);
      check("rst_async_counts", {stall_count, flush_count}, 32'd0);
      check("rst_async_err", mem_err, 0);
      sample();
      next_cycle(); rst_n = 1; idle();
      sample(); check("rst_release", ctl, C_NORMAL);
      check("rst_release_err", mem_err, 0);

      // randomized traffic
      for (int n = 0; n < 2500; n++) begin
         next_cycle();
         id_rs = 5'($urandom_range(0, 7));
         id_rt = 5'($urandom_range(0, 7));
         ex_register_dest = 5'($urandom_range(0, 7));
         id_uses_rt   = ($urandom_range(0, 1) == 1);
         ex_MemRead   = ($urandom_range(0, 9) < 3);
         mem_Branch   = ($urandom_range(0, 9) < 3);
         mem_zero     = ($urandom_range(0, 1) == 1);
         mem_MemRead  = ($urandom_range(0, 9) < 2);
         mem_MemWrite = ($urandom_range(0, 9) < 2);
         dmem_ready   = ($urandom_range(0, 9) < 6);
         rst_n        = ($urandom_range(0, 199) != 0);
      end
      next_cycle(); rst_n = 1; idle();

      // saturation via a long memory hold
      next_cycle(); mem_MemRead = 1; dmem_ready = 0;
      repeat (70000) next_cycle();
      sample(); check("stall_saturate", stall_count, 16'hFFFF);
      check("sat_err", mem_err, 1);
      next_cycle(); idle();
      sample(); check("sat_release", ctl, C_NORMAL);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
